// File: rtl/ddr3_ca_dly_ctrl.sv
// Fabric-side controller for one DDR3 address/command lane output delay line.
// Turns step / absolute / reload commands into spaced MOVE or LOAD pulses and tracks the tap.
module ddr3_ca_dly_ctrl #(
    parameter int MAX_TAPS = 127,
    parameter int LOAD_TAP = 1,
    parameter int STEP_GAP = 4,
    parameter int TAP_W    = 8
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_DIR,
    input  logic [TAP_W-1:0] CMD_TAPS,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic [TAP_W-1:0] TAP_POS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_FIN
    } state_t;

    localparam int               GW       = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
    localparam logic [GW-1:0]    GAP_INIT = GW'(STEP_GAP - 2);
    localparam logic [TAP_W:0]   MAX_X    = (TAP_W + 1)'(MAX_TAPS);
    localparam logic [TAP_W-1:0] LOAD_X   = TAP_W'(LOAD_TAP);
    localparam logic [TAP_W-1:0] ONE      = TAP_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_cnt;
    logic [GW-1:0]    r_gap;
    logic             r_dir;
    logic             r_err;

    logic [TAP_W:0]   w_sum;
    logic             w_res_dir;
    logic [TAP_W-1:0] w_res_cnt;
    logic             w_res_rej;
    logic             w_accept;

    assign w_sum    = {1'b0, r_tap} + {1'b0, CMD_TAPS};
    assign w_accept = CMD_VALID && (r_state == S_IDLE);
    assign TAP_POS  = r_tap;
    assign ERR      = r_err;

    // Resolve the presented command against the current tap position.
    always_comb begin
        w_res_dir = 1'b0;
        w_res_cnt = '0;
        w_res_rej = 1'b0;
        case (CMD_OP)
            2'b00: begin
                w_res_dir = CMD_DIR;
                w_res_cnt = CMD_TAPS;
                w_res_rej = CMD_DIR ? (w_sum > MAX_X) : (CMD_TAPS > r_tap);
            end
            2'b10: begin
                w_res_dir = (CMD_TAPS > r_tap);
                w_res_cnt = w_res_dir ? (CMD_TAPS - r_tap) : (r_tap - CMD_TAPS);
                w_res_rej = ({1'b0, CMD_TAPS} > MAX_X);
            end
            2'b01:   w_res_rej = 1'b0;
            default: w_res_rej = 1'b1;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Rejected and zero-count commands pass through SETUP with a zero count so DONE lands on cycle 2.
    always_comb begin
        w_next               = r_state;
        CMD_READY            = 1'b0;
        BUSY                 = 1'b1;
        DONE                 = 1'b0;
        DELAY_LINE_MOVE      = 1'b0;
        DELAY_LINE_LOAD      = 1'b0;
        DELAY_LINE_DIRECTION = 1'b0;
        case (r_state)
            S_IDLE: begin
                CMD_READY = 1'b1;
                BUSY      = 1'b0;
                if (CMD_VALID) w_next = (CMD_OP == 2'b01) ? S_LOAD : S_SETUP;
            end
            S_LOAD: begin
                DELAY_LINE_LOAD = 1'b1;
                w_next          = S_FIN;
            end
            S_SETUP: begin
                DELAY_LINE_DIRECTION = r_dir;
                w_next               = (r_cnt == '0) ? S_FIN : S_MOVE;
            end
            S_MOVE: begin
                DELAY_LINE_MOVE      = 1'b1;
                DELAY_LINE_DIRECTION = r_dir;
                w_next               = S_GAP;
            end
            S_GAP: begin
                DELAY_LINE_DIRECTION = r_dir;
                if (DELAY_LINE_OUT_OF_RANGE) w_next = S_FIN;
                else if (r_gap == '0)        w_next = (r_cnt != '0) ? S_MOVE : S_FIN;
            end
            S_FIN: begin
                DONE   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_tap <= LOAD_X;
            r_cnt <= '0;
            r_gap <= '0;
            r_dir <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_err <= w_res_rej;
                        r_cnt <= w_res_rej ? '0 : w_res_cnt;
                        r_dir <= !w_res_rej && (w_res_cnt != '0) && (CMD_OP != 2'b01) && w_res_dir;
                    end
                end
                S_LOAD: r_tap <= LOAD_X;
                S_MOVE: begin
                    r_tap <= r_dir ? (r_tap + ONE) : (r_tap - ONE);
                    r_cnt <= r_cnt - ONE;
                    r_gap <= GAP_INIT;
                end
                S_GAP: begin
                    // The line hit its limit: the last move did not take effect.
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        r_err <= 1'b1;
                        r_tap <= r_dir ? (r_tap - ONE) : (r_tap + ONE);
                    end else if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                S_FIN: r_dir <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_ca_dly_ctrl.sv
// Randomized bench for ddr3_ca_dly_ctrl against a cycle-schedule reference model.
module tb_ddr3_ca_dly_ctrl;

    localparam int MAX_TAPS = 127;
    localparam int LOAD_TAP = 1;
    localparam int STEP_GAP = 4;
    localparam int TAP_W    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             vld;
    logic             rdy;
    logic [1:0]       op;
    logic             dir_i;
    logic [TAP_W-1:0] taps;
    logic             mv;
    logic             dly_dir;
    logic             ld;
    logic             oor;
    logic [TAP_W-1:0] tap_pos;
    logic             busy;
    logic             done;
    logic             err;

    int n_vec = 0;
    int n_err = 0;
    int m_pos;

    always #5 clk = ~clk;

    ddr3_ca_dly_ctrl #(
        .MAX_TAPS(MAX_TAPS), .LOAD_TAP(LOAD_TAP), .STEP_GAP(STEP_GAP), .TAP_W(TAP_W)
    ) dut (
        .FAB_CLK(clk),
        .SYNC_RST(rst),
        .CMD_VALID(vld),
        .CMD_READY(rdy),
        .CMD_OP(op),
        .CMD_DIR(dir_i),
        .CMD_TAPS(taps),
        .DELAY_LINE_MOVE(mv),
        .DELAY_LINE_DIRECTION(dly_dir),
        .DELAY_LINE_LOAD(ld),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .TAP_POS(tap_pos),
        .BUSY(busy),
        .DONE(done),
        .ERR(err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {READY, BUSY, MOVE, LOAD, DONE, DIRECTION}
    function automatic logic [5:0] obs();
        return {rdy, busy, mv, ld, done, dly_dir};
    endfunction

    // oor_mv: raise OUT_OF_RANGE in the gap after this (1-based) move, 0 = never.
    task automatic run_cmd(input int c_op, input int c_dir, input int c_taps,
                           input int oor_mv, input int oor_off, input bit hold);
        int       target;
        int       n;
        int       mv_n;
        int       d_end;
        int       t_oor;
        int       exp_pos;
        int       o_mv;
        bit       rej;
        bit       e_dir;
        bit       e_err;
        logic [5:0] e_obs;

        if (c_op == 0)      target = m_pos + (c_dir != 0 ? c_taps : -c_taps);
        else if (c_op == 2) target = c_taps;
        else                target = LOAD_TAP;
        rej   = (c_op == 3) || (target < 0) || (target > MAX_TAPS);
        n     = (rej || c_op == 1) ? 0 : ((target > m_pos) ? target - m_pos : m_pos - target);
        e_dir = (n > 0) && (target > m_pos);
        o_mv  = (oor_mv > n) ? 0 : oor_mv;
        t_oor = (o_mv > 0) ? 2 + (o_mv - 1) * STEP_GAP + 1 + oor_off : -1;
        mv_n  = (o_mv > 0) ? o_mv : n;
        d_end = (o_mv > 0) ? t_oor + 1 : 2 + n * STEP_GAP;
        e_err = rej || (o_mv > 0);
        if (rej)            exp_pos = m_pos;
        else if (c_op == 1) exp_pos = LOAD_TAP;
        else                exp_pos = m_pos + (e_dir ? 1 : -1) * ((o_mv > 0) ? o_mv - 1 : n);

        vld   = 1'b1;
        op    = 2'(c_op);
        dir_i = (c_dir != 0);
        taps  = TAP_W'(c_taps);
        oor   = 1'b0;
        check_val("idle_before_cmd", 32'(obs()), 32'(6'b100000));

        for (int c = 1; c <= d_end + 1; c++) begin
            tick();
            if (!hold || c > d_end) vld = 1'b0;
            oor = (c == t_oor);
            e_obs[5] = (c > d_end);
            e_obs[4] = (c <= d_end);
            e_obs[3] = (c >= 2) && (c < d_end) && ((c - 2) % STEP_GAP == 0) && ((c - 2) / STEP_GAP < mv_n);
            e_obs[2] = (c_op == 1) && (c == 1);
            e_obs[1] = (c == d_end);
            e_obs[0] = e_dir && (c < d_end);
            check_val($sformatf("outputs op%0d cyc%0d", c_op, c), 32'(obs()), 32'(e_obs));
            if (c == 1 && !rej) check_val("err_cleared_on_accept", 32'(err), 32'(0));
            if (c >= d_end)     check_val($sformatf("err op%0d cyc%0d", c_op, c), 32'(err), 32'(e_err));
        end
        oor = 1'b0;
        check_val($sformatf("tap_pos op%0d", c_op), 32'(tap_pos), 32'(exp_pos));
        m_pos = exp_pos;
    endtask

    initial begin
        int r;
        int r_op;
        int r_taps;
        int r_mv;

        rst = 1'b1; vld = 1'b0; op = 2'b00; dir_i = 1'b0; taps = '0; oor = 1'b0;
        tick();
        tick();
        check_val("reset_outputs", 32'(obs()), 32'(6'b100000));
        check_val("reset_tap", 32'(tap_pos), 32'(LOAD_TAP));
        check_val("reset_err", 32'(err), 32'(0));
        rst = 1'b0;
        tick();
        check_val("post_reset_outputs", 32'(obs()), 32'(6'b100000));
        m_pos = LOAD_TAP;

        run_cmd(0, 1, 3, 0, 0, 1'b0);
        run_cmd(2, 0, 2, 0, 0, 1'b0);
        run_cmd(0, 0, 5, 0, 0, 1'b0);
        run_cmd(0, 1, 10, 3, 0, 1'b0);
        run_cmd(1, 0, 0, 0, 0, 1'b1);
        run_cmd(0, 1, 127, 0, 0, 1'b0);
        run_cmd(0, 1, 1, 0, 0, 1'b0);
        run_cmd(2, 0, 0, 0, 0, 1'b0);
        run_cmd(0, 0, 1, 0, 0, 1'b0);
        run_cmd(3, 1, 4, 0, 0, 1'b0);
        run_cmd(0, 1, 0, 0, 0, 1'b1);

        // Reset in the gap after the second move of a 5-tap step.
        vld = 1'b1; op = 2'b00; dir_i = 1'b1; taps = TAP_W'(5);
        tick();
        vld = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        check_val("tap_before_reset", 32'(tap_pos), 32'(m_pos + 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("reset_mid_gap_outputs", 32'(obs()), 32'(6'b100000));
        check_val("reset_mid_gap_tap", 32'(tap_pos), 32'(LOAD_TAP));
        for (int c = 0; c < 2 * STEP_GAP; c++) begin
            tick();
            check_val("quiet_after_reset", 32'(obs()), 32'(6'b100000));
        end
        m_pos = LOAD_TAP;

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4)      r_op = 0;
            else if (r <= 7) r_op = 2;
            else if (r == 8) r_op = 1;
            else             r_op = 3;
            if (r_op == 2)                        r_taps = int'($urandom_range(0, 160));
            else if ($urandom_range(0, 7) == 0)   r_taps = int'($urandom_range(0, 255));
            else                                  r_taps = int'($urandom_range(0, 40));
            r_mv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_cmd(r_op, int'($urandom_range(0, 1)), r_taps, r_mv,
                    int'($urandom_range(0, STEP_GAP - 2)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
